regfile_wr_arbiter: RTL

//  Shares the register file's single write port between two writers: the pipeline

---
 rtl/cpu_pkg.sv | 14 +
 rtl/regfile_wr_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and the write-port arbiter state encoding.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (priority) and mul/div,
// forcing a mul/div grant with a pipeline stall once mul/div has been blocked too long.
module regfile_wr_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = REG_AW,
    parameter int DW           = REG_DW
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          pipe_valid,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_data,
    output logic          pipe_ready,
    input  logic          md_valid,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    output logic          stall_req,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state_reg, state_next;
    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
    logic          pipe_acc;
    logic          md_acc;
    logic          md_blocked;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg      <= ARB_NORMAL;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        pipe_ready      = 1'b1;
        stall_req       = 1'b0;
        md_ready        = ~pipe_valid;
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;

        if (state_reg == ARB_FORCE) begin
            pipe_ready = 1'b0;
            stall_req  = 1'b1;
            md_ready   = 1'b1;
        end

        md_blocked = (state_reg == ARB_NORMAL) && md_valid && !md_ready;

        case (state_reg)
            ARB_NORMAL: begin
                if (md_blocked && (starve_cnt_reg == CW'(STARVE_LIMIT - 1)))
                    state_next = ARB_FORCE;
            end
            // The forced cycle always grants mul/div (or aborts on a dropped request).
            default: state_next = ARB_NORMAL;
        endcase

        if (!md_valid || md_ready)
            starve_cnt_next = '0;
        else if (md_blocked && (starve_cnt_reg != CW'(STARVE_LIMIT)))
            starve_cnt_next = starve_cnt_reg + CW'(1);
    end

    assign pipe_acc = pipe_valid & pipe_ready;
    assign md_acc   = md_valid & md_ready;

    // r0 is hardwired: its writes handshake normally but never raise wr_en.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (pipe_acc) begin
            wr_en   <= (pipe_addr != AW'(REG_ZERO));
            wr_addr <= pipe_addr;
            wr_data <= pipe_data;
        end else if (md_acc) begin
            wr_en   <= (md_addr != AW'(REG_ZERO));
            wr_addr <= md_addr;
            wr_data <= md_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // A forced grant with no pending mul/div result is a protocol violation.
    force_needs_md: assert property (@(posedge clk) disable iff (!rstb)
        (state_reg == ARB_FORCE) |-> md_valid);

endmodule
